mem_arbiter: RTL and testbench

//  Shares the single SPI SRAM memory controller between two requesters: port A (instruction fetch,

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SPI SRAM controller between fetch port A and data port B, with a stall watchdog.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port B always wins ties.
module mem_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_done,
    output logic              a_err,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_value,
    output logic              mem_write_enable,
    output logic              mem_request,
    input  logic [DATA_W-1:0] mem_read_value,
    input  logic              mem_request_complete
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    // Abort on the BUSY cycle whose incremented count would reach all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(2 ** TMO_W - 2);
    state_t           state;
    logic [TMO_W-1:0] wdog;
    logic             owner_b;
    logic             pick_b;
`ifdef MEM_ARB_RR_EN
    logic last_b;
    assign pick_b = b_req & (~a_req | ~last_b);
`else
    assign pick_b = b_req;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wdog             <= '0;
            owner_b          <= 1'b0;
            a_rdata          <= '0;
            b_rdata          <= '0;
            a_done           <= 1'b0;
            b_done           <= 1'b0;
            a_err            <= 1'b0;
            b_err            <= 1'b0;
            mem_address      <= '0;
            mem_write_value  <= '0;
            mem_write_enable <= 1'b0;
            mem_request      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_b           <= 1'b1;
`endif
        end else begin
            a_done <= 1'b0;
            b_done <= 1'b0;
            a_err  <= 1'b0;
            b_err  <= 1'b0;
            case (state)
                IDLE: if (ena && (a_req || b_req)) begin
                    owner_b          <= pick_b;
                    mem_address      <= pick_b ? b_addr : a_addr;
                    mem_write_value  <= pick_b ? b_wdata : '0;
                    mem_write_enable <= pick_b & b_we;
                    mem_request      <= 1'b1;
                    wdog             <= '0;
                    state            <= BUSY;
`ifdef MEM_ARB_RR_EN
                    last_b           <= pick_b;
`endif
                end
                BUSY: if (mem_request_complete) begin
                    mem_request      <= 1'b0;
                    mem_write_enable <= 1'b0;
                    state            <= RELEASE;
                    if (owner_b) begin
                        b_done <= 1'b1;
                        if (!mem_write_enable) b_rdata <= mem_read_value;
                    end else begin
                        a_done  <= 1'b1;
                        a_rdata <= mem_read_value;
                    end
                end else if (wdog == TMO_LAST) begin
                    mem_request      <= 1'b0;
                    mem_write_enable <= 1'b0;
                    a_err            <= ~owner_b;
                    b_err            <= owner_b;
                    state            <= RELEASE;
                end else begin
                    wdog <= wdog + 1'b1;
                end
                RELEASE: if (!mem_request_complete) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    localparam int AW = 17, DW = 16;
    logic clk = 0, rst_n = 1, ena = 0, a_req = 0, b_req = 0, b_we = 0, cpl = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] b_wdata = '0, mem_read_value = '0;
    logic [DW-1:0] a_rdata, b_rdata, mem_write_value;
    logic [AW-1:0] mem_address;
    logic a_done, b_done, a_err, b_err, mem_write_enable, mem_request;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata), .a_done(a_done),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_done(b_done), .a_err(a_err), .b_err(b_err),
        .mem_address(mem_address), .mem_write_value(mem_write_value),
        .mem_write_enable(mem_write_enable), .mem_request(mem_request),
        .mem_read_value(mem_read_value), .mem_request_complete(cpl)
    );

    always #5 clk = ~clk;

    int n_test = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access, its age, and the drain wait after it.
    logic e_a_done, e_b_done, e_a_err, e_b_err, e_mem_req, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wv, e_a_rdata, e_b_rdata;
    bit txn_active, draining, txn_b, txn_we, last_b, rand_mode;
    int txn_age;
    int cnt, lat, hold, force_lat = 0;
    bit cnt_act, rv_force_en;
    logic [DW-1:0] rv_force;

    task automatic model_reset();
        {e_a_done, e_b_done, e_a_err, e_b_err, e_mem_req, e_we} = '0;
        e_addr = '0; e_wv = '0; e_a_rdata = '0; e_b_rdata = '0;
        txn_active = 0; draining = 0; last_b = 1; txn_age = 0;
        cpl = 0; cnt_act = 0;
    endtask

    task automatic model_update();
        {e_a_done, e_b_done, e_a_err, e_b_err} = '0;
        if (draining) draining = cpl;
        else if (txn_active) begin
            txn_age++;
            if (cpl || txn_age == 255) begin
                if (cpl) begin
                    if (txn_b) begin
                        e_b_done = 1;
                        if (!txn_we) e_b_rdata = mem_read_value;
                    end else begin
                        e_a_done = 1;
                        e_a_rdata = mem_read_value;
                    end
                end else if (txn_b) e_b_err = 1;
                else e_a_err = 1;
                txn_active = 0; draining = 1; e_mem_req = 0; e_we = 0;
            end
        end else if (ena && (a_req || b_req)) begin
`ifdef MEM_ARB_RR_EN
            txn_b = (a_req && b_req) ? !last_b : b_req;
`else
            txn_b = b_req;
`endif
            last_b = txn_b;
            txn_we = txn_b && b_we;
            e_addr = txn_b ? b_addr : a_addr;
            e_wv = b_wdata;
            txn_active = 1; txn_age = 0; e_mem_req = 1; e_we = txn_we;
        end
    endtask

    // Controller model: completes after lat request cycles (-1 never), holds complete a few cycles after drop.
    task automatic ctrl_update();
        int r;
        if (e_mem_req) begin
            if (!cnt_act) begin
                r = int'($urandom_range(15));
                cnt_act = 1; cnt = 0; hold = int'($urandom_range(2));
                lat = force_lat != 0 ? force_lat : r == 0 ? -1 : r == 1 ? 255 : r == 2 ? 256 : int'($urandom_range(60, 1));
            end
            cnt++;
            if (lat > 0 && cnt >= lat) cpl = 1;
        end else begin
            cnt_act = 0;
            if (cpl) begin
                if (hold > 0) hold--;
                else cpl = 0;
            end
        end
        mem_read_value = rv_force_en ? rv_force : DW'($urandom);
    endtask

    task automatic req_update();
        if (e_a_done || e_a_err) a_req = $urandom_range(2) == 0;
        else if (!a_req && !(txn_active && !txn_b)) a_req = $urandom_range(3) == 0;
        else if (a_req && txn_active && !txn_b && $urandom_range(40) == 0) a_req = 0;
        if (e_b_done || e_b_err) b_req = $urandom_range(2) == 0;
        else if (!b_req && !(txn_active && txn_b)) b_req = $urandom_range(3) == 0;
        else if (b_req && txn_active && txn_b && $urandom_range(40) == 0) b_req = 0;
        if ($urandom_range(1) == 1) a_addr = AW'($urandom);
        if ($urandom_range(1) == 1) begin
            b_addr = AW'($urandom); b_wdata = DW'($urandom); b_we = $urandom_range(1) == 1;
        end
        ena = $urandom_range(9) != 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
        ctrl_update();
        if (rand_mode) req_update();
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((txn_active || draining) && k < 600) begin
            step();
            k++;
        end
        chk(name, k < 600, 1);
        step();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rdata"}, {a_rdata, b_rdata}, 0);
        chk({name, "_addr"}, mem_address, 0);
        chk({name, "_wval"}, mem_write_value, 0);
        chk({name, "_ctl"}, {a_done, b_done, a_err, b_err, mem_write_enable, mem_request}, 0);
    endtask

    always @(negedge clk) if (rst_n) begin
        chk("a_done", a_done, e_a_done);
        chk("b_done", b_done, e_b_done);
        chk("a_err", a_err, e_a_err);
        chk("b_err", b_err, e_b_err);
        chk("mem_request", mem_request, e_mem_req);
        chk("mem_write_enable", mem_write_enable, e_we);
        chk("a_rdata", a_rdata, e_a_rdata);
        chk("b_rdata", b_rdata, e_b_rdata);
        if (e_mem_req) chk("mem_address", mem_address, e_addr);
        if (e_mem_req && e_we) chk("mem_write_value", mem_write_value, e_wv);
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nd, ne, nh, ng;
        logic [3:0] seq;
        logic [DW-1:0] br;
        bit prev;
        model_reset();
        #1 rst_n = 0;
        #10 chk_zero("reset");
        #11 rst_n = 1;
        ena = 1;
        repeat (2) step();

        // Plain A read
        rv_force_en = 1; rv_force = 16'hBEEF; force_lat = 48;
        a_addr = 17'h1_0040; a_req = 1;
        step();
        chk("t1_req_latency", mem_request, 1);
        chk("t1_addr", mem_address, 17'h1_0040);
        nd = 0;
        repeat (60) begin
            step();
            if (e_a_done) a_req = 0;
            if (a_done) nd++;
        end
        chk("t1_done_count", nd, 1);
        chk("t1_rdata", a_rdata, 16'hBEEF);
        chk("t1_req_low", mem_request, 0);
        drain("t1_drain");

        // Both ports held for four grants; last grant so far was A
        rv_force_en = 0; force_lat = 5;
        b_we = 1; b_addr = 17'h0_0077; b_wdata = 16'h1111; a_addr = 17'h0_0042;
        a_req = 1; b_req = 1; ng = 0; seq = '0; prev = 0;
        repeat (100) if (ng < 4) begin
            step();
            if (mem_request && !prev) begin
                seq[ng] = mem_write_enable;
                ng++;
                if (ng == 4) begin a_req = 0; b_req = 0; end
            end
            prev = mem_request;
        end
        chk("t3_grant_count", ng, 4);
`ifdef MEM_ARB_RR_EN
        chk("t3_grant_order", seq, 4'b0101);
`else
        chk("t3_grant_order", seq, 4'b1111);
`endif
        drain("t3_drain");

        // B write; inputs changed after grant must not leak through
        force_lat = 10; br = b_rdata;
        b_we = 1; b_addr = 17'h0_0123; b_wdata = 16'h5A5A; b_req = 1;
        step();
        nd = 0;
        repeat (30) begin
            if (mem_request) begin
                chk("t2_we", mem_write_enable, 1);
                chk("t2_wval", mem_write_value, 16'h5A5A);
                chk("t2_addr", mem_address, 17'h0_0123);
            end
            b_wdata = DW'($urandom); b_addr = AW'($urandom);
            step();
            if (e_b_done) b_req = 0;
            if (b_done) nd++;
        end
        chk("t2_done_count", nd, 1);
        chk("t2_rdata_kept", b_rdata, br);
        drain("t2_drain");

        // Completion on the watchdog terminal cycle wins, then a true timeout
        for (int t = 0; t < 2; t++) begin
            force_lat = t == 0 ? 255 : -1; b_we = 0; b_req = 1;
            nd = 0; ne = 0; nh = 0;
            repeat (300) begin
                step();
                if (e_b_done || e_b_err) b_req = 0;
                if (mem_request) nh++;
                if (b_done) nd++;
                if (b_err) ne++;
            end
            chk(t == 0 ? "t4_edge_done" : "t4_timeout_done", nd, t == 0 ? 1 : 0);
            chk(t == 0 ? "t4_edge_err" : "t4_timeout_err", ne, t == 0 ? 0 : 1);
            chk(t == 0 ? "t4_edge_busy" : "t4_timeout_busy", nh, 255);
            drain("t4_drain");
            chk("t4_req_low", mem_request, 0);
        end

        // ena gating
        ena = 0; force_lat = 3; a_addr = 17'h0_0abc; a_req = 1;
        repeat (5) begin
            step();
            chk("t6_no_grant", mem_request, 0);
        end
        ena = 1;
        step();
        chk("t6_grant", mem_request, 1);
        ena = 0; nd = 0;
        repeat (20) begin
            step();
            if (e_a_done) a_req = 0;
            if (a_done) nd++;
        end
        chk("t6_done_ena_low", nd, 1);
        ena = 1;
        drain("t6_drain");

        // Asynchronous reset mid-access
        force_lat = -1; a_addr = 17'h1_2345; a_req = 1;
        repeat (10) step();
        #2 rst_n = 0;
        model_reset();
        #1 chk_zero("t5_async");
        a_req = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        force_lat = 7; rv_force_en = 1; rv_force = 16'h1234; a_req = 1; nd = 0;
        repeat (20) begin
            step();
            if (e_a_done) a_req = 0;
            if (a_done) nd++;
        end
        chk("t5_done", nd, 1);
        chk("t5_rdata", a_rdata, 16'h1234);
        drain("t5_drain");

        // Randomized traffic
        rand_mode = 1; force_lat = 0; rv_force_en = 0;
        repeat (8000) step();
        rand_mode = 0; a_req = 0; b_req = 0; ena = 1;
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule
